// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - op codes and lane helper shared by the data memory/stack block
package data_memory_pkg;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_STORE = 2'b01;
   localparam logic [1:0] OP_PUSH  = 2'b10;
   localparam logic [1:0] OP_POP   = 2'b11;

   // Number of byte lanes in a data word.
   function automatic int lane_count(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/byte_en_ram.sv
// rtl/byte_en_ram.sv - single-port RAM, registered read, per-byte-lane write mask
module byte_en_ram
   import data_memory_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
)(
   input  logic                              clk,
   input  logic                              we_i,
   input  logic                              re_i,
   input  logic [ADDR_WIDTH-1:0]             addr_i,
   input  logic [DATA_WIDTH-1:0]             wdata_i,
   input  logic [lane_count(DATA_WIDTH)-1:0] wmask_i,
   output logic [DATA_WIDTH-1:0]             rdata_o
);

   localparam int LANES = lane_count(DATA_WIDTH);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Read returns the pre-write contents; callers never read and write one slot in the same cycle.
   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int i = 0; i < LANES; i++) begin
            if (wmask_i[i]) begin
               mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
         end
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_stack.sv
// rtl/data_memory_stack.sv - word-addressed data RAM plus hardware LIFO stack with
// overflow/underflow detection and one-cycle registered read responses
module data_memory_stack
   import data_memory_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12,
   parameter int STACK_AW   = 8
)(
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              req_valid,
   input  logic [1:0]                        req_op,
   input  logic [ADDR_WIDTH-1:0]             address,
   input  logic [DATA_WIDTH-1:0]             data,
   input  logic [lane_count(DATA_WIDTH)-1:0] byte_en,
   input  logic                              err_clear,
   output logic                              rsp_valid,
   output logic [DATA_WIDTH-1:0]             data_mem_out,
   output logic [STACK_AW:0]                 sp,
   output logic                              stack_empty,
   output logic                              stack_full,
   output logic                              err_overflow,
   output logic                              err_underflow
);

   localparam int LANES = lane_count(DATA_WIDTH);
   localparam logic [STACK_AW:0]   SP_FULL = (STACK_AW+1)'(2 ** STACK_AW);
   localparam logic [STACK_AW:0]   SP_ONE  = (STACK_AW+1)'(1);
   localparam logic [STACK_AW-1:0] IDX_ONE = STACK_AW'(1);

   logic [STACK_AW:0]     sp_q, sp_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic                  rsp_q, rsp_d;
   logic                  sel_stack_q, sel_stack_d;
   logic [DATA_WIDTH-1:0] hold_q;
   logic [DATA_WIDTH-1:0] dm_rdata, stk_rdata, out_w;

   logic                  is_full, is_empty;
   logic                  do_load, do_store, push_req, pop_req, push_ok, pop_ok;
   logic                  dm_we, dm_re, stk_we, stk_re;
   logic [STACK_AW-1:0]   stk_idx;

   assign is_full  = (sp_q == SP_FULL);
   assign is_empty = (sp_q == '0);

   assign do_load  = req_valid && (req_op == OP_LOAD);
   assign do_store = req_valid && (req_op == OP_STORE);
   assign push_req = req_valid && (req_op == OP_PUSH);
   assign pop_req  = req_valid && (req_op == OP_POP);
   assign push_ok  = push_req && !is_full;
   assign pop_ok   = pop_req && !is_empty;

   // Reset in the same cycle as a request suppresses every write and read.
   assign dm_we  = !reset && do_store;
   assign dm_re  = !reset && do_load;
   assign stk_we = !reset && push_ok;
   assign stk_re = !reset && pop_ok;

   // Push writes the free slot at sp; pop reads the top slot at sp-1.
   assign stk_idx = push_ok ? sp_q[STACK_AW-1:0] : (sp_q[STACK_AW-1:0] - IDX_ONE);

   always_comb begin
      sp_d        = sp_q;
      ovf_d       = ovf_q && !err_clear;
      unf_d       = unf_q && !err_clear;
      rsp_d       = do_load || pop_ok;
      sel_stack_d = pop_ok;
      if (push_ok) begin
         sp_d = sp_q + SP_ONE;
      end else if (pop_ok) begin
         sp_d = sp_q - SP_ONE;
      end
      // A fresh error event outranks a simultaneous clear.
      if (push_req && is_full) begin
         ovf_d = 1'b1;
      end
      if (pop_req && is_empty) begin
         unf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sp_q        <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         rsp_q       <= 1'b0;
         sel_stack_q <= 1'b0;
         hold_q      <= '0;
      end else begin
         sp_q        <= sp_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         rsp_q       <= rsp_d;
         sel_stack_q <= sel_stack_d;
         hold_q      <= out_w;
      end
   end

   byte_en_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_dm (
      .clk     (clk),
      .we_i    (dm_we),
      .re_i    (dm_re),
      .addr_i  (address),
      .wdata_i (data),
      .wmask_i (byte_en),
      .rdata_o (dm_rdata)
   );

   byte_en_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (STACK_AW)
   ) u_stack (
      .clk     (clk),
      .we_i    (stk_we),
      .re_i    (stk_re),
      .addr_i  (stk_idx),
      .wdata_i (data),
      .wmask_i ({LANES{1'b1}}),
      .rdata_o (stk_rdata)
   );

   // Between responses the output holds the last returned word.
   assign out_w = rsp_q ? (sel_stack_q ? stk_rdata : dm_rdata) : hold_q;

   assign rsp_valid     = rsp_q;
   assign data_mem_out  = out_w;
   assign sp            = sp_q;
   assign stack_empty   = is_empty;
   assign stack_full    = is_full;
   assign err_overflow  = ovf_q;
   assign err_underflow = unf_q;

endmodule

// File: tb/tb_data_memory_stack.sv
// tb/tb_data_memory_stack.sv - randomized check of data_memory_stack against a queue/array model
module tb_data_memory_stack;

   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int SAW   = 2;
   localparam int LANES = DW / 8;
   localparam int SDEP  = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             req_valid;
   logic [1:0]       req_op;
   logic [AW-1:0]    address;
   logic [DW-1:0]    data;
   logic [LANES-1:0] byte_en;
   logic             err_clear;
   logic             rsp_valid;
   logic [DW-1:0]    data_mem_out;
   logic [SAW:0]     sp;
   logic             stack_empty, stack_full, err_overflow, err_underflow;

   data_memory_stack #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STACK_AW(SAW)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_op        (req_op),
      .address       (address),
      .data          (data),
      .byte_en       (byte_en),
      .err_clear     (err_clear),
      .rsp_valid     (rsp_valid),
      .data_mem_out  (data_mem_out),
      .sp            (sp),
      .stack_empty   (stack_empty),
      .stack_full    (stack_full),
      .err_overflow  (err_overflow),
      .err_underflow (err_underflow)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] m_dm [2**AW];
   logic [DW-1:0] m_stk [$];
   logic          m_ovf, m_unf, m_rsp;
   logic [DW-1:0] m_out;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic compare_all();
      chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp));
      chk("data_mem_out", 64'(data_mem_out), 64'(m_out));
      chk("sp", 64'(sp), 64'(m_stk.size()));
      chk("stack_empty", 64'(stack_empty), 64'(m_stk.size() == 0));
      chk("stack_full", 64'(stack_full), 64'(m_stk.size() == SDEP));
      chk("err_overflow", 64'(err_overflow), 64'(m_ovf));
      chk("err_underflow", 64'(err_underflow), 64'(m_unf));
   endtask

   task automatic model_update(input logic r, input logic v, input logic [1:0] op,
                               input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [LANES-1:0] be, input logic clr);
      logic ev_o, ev_u;
      if (r) begin
         m_stk.delete();
         m_ovf = 0; m_unf = 0; m_rsp = 0; m_out = '0;
         return;
      end
      ev_o = 0; ev_u = 0; m_rsp = 0;
      if (v) begin
         case (op)
            2'b00: begin m_rsp = 1; m_out = m_dm[a]; end
            2'b01: for (int i = 0; i < LANES; i++) if (be[i]) m_dm[a][i*8 +: 8] = d[i*8 +: 8];
            2'b10: if (m_stk.size() == SDEP) ev_o = 1; else m_stk.push_back(d);
            default: if (m_stk.size() == 0) ev_u = 1; else begin m_out = m_stk.pop_back(); m_rsp = 1; end
         endcase
      end
      m_ovf = ev_o | (m_ovf & ~clr);
      m_unf = ev_u | (m_unf & ~clr);
   endtask

   task automatic step(input logic r, input logic v, input logic [1:0] op,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [LANES-1:0] be, input logic clr);
      reset = r; req_valid = v; req_op = op; address = a; data = d; byte_en = be; err_clear = clr;
      @(posedge clk);
      model_update(r, v, op, a, d, be, clr);
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle();       step(0, 0, 2'b00, '0, '0, '0, 0); endtask
   task automatic push(input logic [DW-1:0] d); step(0, 1, 2'b10, '0, d, '0, 0); endtask
   task automatic pop();        step(0, 1, 2'b11, '0, '0, '0, 0); endtask

   initial begin
      m_ovf = 0; m_unf = 0; m_rsp = 0; m_out = '0;
      step(1, 0, 2'b00, '0, '0, '0, 0);
      step(1, 1, 2'b10, '0, 32'h55, '0, 0);
      idle();
      chk("reset sp", 64'(sp), 64'd0);
      chk("reset empty", 64'(stack_empty), 64'd1);
      chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset data_mem_out", 64'(data_mem_out), 64'd0);

      for (int i = 0; i < 2**AW; i++) step(0, 1, 2'b01, AW'(i), $urandom, '1, 0);

      step(0, 1, 2'b01, 4'h5, 32'hDEADBEEF, 4'b1111, 0);
      step(0, 1, 2'b01, 4'h5, 32'h000000AA, 4'b0001, 0);
      step(0, 1, 2'b00, 4'h5, '0, '0, 0);
      chk("lane merge rsp", 64'(rsp_valid), 64'd1);
      chk("lane merge data", 64'(data_mem_out), 64'hDEADBEAA);

      push(32'h11); push(32'h22); push(32'h33);
      chk("three pushes sp", 64'(sp), 64'd3);
      pop(); chk("pop1 data", 64'(data_mem_out), 64'h33); chk("pop1 sp", 64'(sp), 64'd2);
      pop(); chk("pop2 data", 64'(data_mem_out), 64'h22); chk("pop2 sp", 64'(sp), 64'd1);
      pop(); chk("pop3 data", 64'(data_mem_out), 64'h11); chk("pop3 sp", 64'(sp), 64'd0);
      chk("drained empty", 64'(stack_empty), 64'd1);

      for (int i = 1; i <= 5; i++) push(DW'(i));
      chk("overflow sp", 64'(sp), 64'd4);
      chk("overflow full", 64'(stack_full), 64'd1);
      chk("overflow flag", 64'(err_overflow), 64'd1);
      pop();
      chk("top unchanged", 64'(data_mem_out), 64'd4);
      pop(); pop(); pop();
      pop();
      chk("underflow flag", 64'(err_underflow), 64'd1);
      chk("underflow no rsp", 64'(rsp_valid), 64'd0);

      step(0, 1, 2'b11, '0, '0, '0, 1);
      chk("clear vs event unf", 64'(err_underflow), 64'd1);
      step(0, 0, 2'b00, '0, '0, '0, 1);
      chk("clear ovf", 64'(err_overflow), 64'd0);
      chk("clear unf", 64'(err_underflow), 64'd0);

      push(32'hA1); push(32'hA2);
      step(1, 1, 2'b10, '0, 32'hA3, '0, 0);
      chk("reset mid push sp", 64'(sp), 64'd0);
      pop();
      chk("pop after reset unf", 64'(err_underflow), 64'd1);

      for (int n = 0; n < 3000; n++) begin
         logic r, v, c;
         r = ($urandom_range(0, 99) == 0);
         v = ($urandom_range(0, 99) < 85);
         c = ($urandom_range(0, 99) < 5);
         step(r, v, 2'($urandom_range(0, 3)), AW'($urandom), $urandom, LANES'($urandom), c);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/data_memory_stack.md
# data_memory_stack

Parametrised successor to the core's data memory: one single-clock block holding a word-addressed data RAM and a hardware-managed LIFO stack region with its own stack pointer. The core issues one request per cycle (load, store, push, pop) on a valid-qualified bus. Loads and pops return registered data one cycle later. Stores support byte lanes, and stack over/underflow is detected and flagged instead of corrupting memory.

## Interface
Parameters:
- DATA_WIDTH, 32: word width; must be a multiple of 8.
- ADDR_WIDTH, 12: data RAM address width; RAM depth is 2**ADDR_WIDTH words.
- STACK_AW, 8: stack address width; stack depth is 2**STACK_AW words.

Ports:
- clk  in  1  single clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present this cycle; the block always accepts it.
- req_op  in  2  operation: 00 load, 01 store, 10 push, 11 pop.
- address  in  ADDR_WIDTH  RAM word address; used by load and store only.
- data  in  DATA_WIDTH  write data for store and push.
- byte_en  in  DATA_WIDTH/8  store lane enables; bit i covers bits 8i+7:8i; ignored for push.
- err_clear  in  1  clears the sticky error flags.
- rsp_valid  out  1  data_mem_out is valid this cycle.
- data_mem_out  out  DATA_WIDTH  load or pop result.
- sp  out  STACK_AW+1  current stack occupancy, 0..2**STACK_AW.
- stack_empty  out  1  asserted when sp == 0.
- stack_full  out  1  asserted when sp == 2**STACK_AW.
- err_overflow  out  1  sticky: a push was attempted while full.
- err_underflow  out  1  sticky: a pop was attempted while empty.

## Operation
- Load: read dm[address]. Result appears on data_mem_out with rsp_valid high on the next cycle.
- Store: write dm[address] on lanes where byte_en=1; other lanes keep their old value. No response.
- Push, not full: write stack[sp] with the full word, then sp <= sp+1. No response.
- Pop, not empty: sp <= sp-1 and read stack[sp-1]. Response arrives on the next cycle.
- Push while full: no write, sp unchanged, err_overflow <= 1, no response.
- Pop while empty: no write, sp unchanged, err_underflow <= 1, rsp_valid stays 0 and data_mem_out holds its previous value.
- req_valid=0: no state change; rsp_valid=0 on the next cycle.
- err_clear: clears both sticky flags. If an error event occurs in the same cycle, the event wins and its flag is set.
- Address spaces: stack and RAM are disjoint arrays. address never reaches the stack region.
- stack_full and stack_empty are combinational decodes of sp.
- sp counts occupancy (STACK_AW+1 bits), so full and empty are unambiguous. The array index is sp[STACK_AW-1:0].

## Timing
- Reset values: sp=0, rsp_valid=0, data_mem_out=0, err_overflow=0, err_underflow=0, stack_empty=1, stack_full=0. RAM and stack contents are not cleared.
- A reset cycle overrides any request in that cycle; no write and no pointer change occur.
- Read latency is exactly 1 cycle. rsp_valid is a 1-cycle pulse per successful load or pop.
- Throughput is 1 request per cycle with no stalls.
- Store then load of the same address on consecutive cycles returns the new data. The write commits at edge N and the read samples at edge N+1.
- Push then pop on consecutive cycles returns the pushed word.
- Pop then push on consecutive cycles: the push overwrites the slot just freed.
- sp and the flags are visible one cycle after the request edge.

## Structure
- Package data_memory_pkg holds:
  - the op-code localparams OP_LOAD, OP_STORE, OP_PUSH, OP_POP;
  - the byte-lane count function DATA_WIDTH/8.
- One sub-module, byte_en_ram: a single-port RAM with a registered read and a per-lane write mask.
  - Instantiate it twice: dm with byte_en, and stack with all lanes enabled.
- The top level holds the sp counter, error logic, response register and output mux. There is no FSM beyond the sp counter.

## Test plan
- Reset, then idle: sp=0, stack_empty=1, rsp_valid=0, data_mem_out=0.
- Store 0xDEADBEEF to address 0x005 with byte_en=1111, then store 0x000000AA with byte_en=0001, then load 0x005: one cycle later rsp_valid=1 and data_mem_out=0xDEADBEAA.
- Push 0x11, 0x22, 0x33, then pop three times: responses are 0x33, 0x22, 0x11; sp steps 3, 2, 1, 0; stack_empty=1 at the end.
- With STACK_AW=2, push 5 times: sp saturates at 4, stack_full=1, err_overflow=1 after the fifth push, and the top word is unchanged. Then pop while empty after draining: err_underflow=1 and no rsp_valid.
- Assert err_clear while a pop on an empty stack happens in the same cycle: err_underflow stays 1. Assert err_clear alone the next cycle: both flags are 0.
- Assert reset during back-to-back pushes with sp=2: the next cycle shows sp=0 and no write. Then pop: underflow is flagged.
